// File: rtl/cacheline_adapter_pkg.sv
// Shared types and geometry for the cache-line to bmem burst adapter.
package rv32i_types;

  localparam int unsigned BEAT_W     = 64;
  localparam int unsigned BURST_LEN  = 4;
  localparam int unsigned LINE_W     = BEAT_W * BURST_LEN;
  localparam int unsigned OFFSET_W   = $clog2(LINE_W / 8);
  localparam int unsigned CNT_W      = $clog2(BURST_LEN);
  localparam int unsigned BEAT_SH    = $clog2(BEAT_W);
  localparam int unsigned LINE_IDX_W = $clog2(LINE_W);

  localparam logic [31:0] LINE_ADDR_MASK = ~32'((LINE_W / 8) - 1);

  typedef enum logic [2:0] {
    A_IDLE,
    A_RD_REQ,
    A_RD_WAIT,
    A_WR_BURST,
    A_DONE
  } adapter_state_t;

  // Bit offset of beat `cnt` inside the line buffer.
  function automatic logic [LINE_IDX_W-1:0] beat_lsb(logic [CNT_W-1:0] cnt);
    return {cnt, {BEAT_SH{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_adapter_if.sv
// Cache-side (dfp) and memory-side (bmem) bundles of the line adapter.
interface cacheline_dfp_if
  import rv32i_types::*;
;
  logic [31:0]     dfp_addr;
  logic            dfp_read;
  logic            dfp_write;
  logic [LINE_W-1:0] dfp_wdata;
  logic [LINE_W-1:0] dfp_rdata;
  logic            dfp_resp;

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp
  );

  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp
  );
endinterface

interface cacheline_bmem_if
  import rv32i_types::*;
;
  logic [31:0]     bmem_addr;
  logic            bmem_read;
  logic            bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic            bmem_ready;
  logic [31:0]     bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic            bmem_rvalid;

  modport master (
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport slave (
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/cacheline_adapter.sv
// Converts 256-bit cache line reads/writes into 4-beat 64-bit bmem bursts,
// one transaction outstanding at a time.
module cacheline_adapter
  import rv32i_types::*;
(
  input  logic             clk,
  input  logic             rst,
  cacheline_dfp_if.slave   dfp,
  cacheline_bmem_if.master bmem
);

  adapter_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [LINE_W-1:0] line_q, line_d;

  logic last_beat;
  assign last_beat = (cnt_q == CNT_W'(BURST_LEN - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;

    dfp.dfp_rdata   = '0;
    dfp.dfp_resp    = 1'b0;
    bmem.bmem_addr  = '0;
    bmem.bmem_read  = 1'b0;
    bmem.bmem_write = 1'b0;
    bmem.bmem_wdata = '0;

    unique case (state_q)
      A_IDLE: begin
        // Write has priority; a concurrent read is simply not taken.
        if (dfp.dfp_write) begin
          addr_d  = dfp.dfp_addr & LINE_ADDR_MASK;
          line_d  = dfp.dfp_wdata;
          cnt_d   = '0;
          state_d = A_WR_BURST;
        end else if (dfp.dfp_read) begin
          addr_d  = dfp.dfp_addr & LINE_ADDR_MASK;
          cnt_d   = '0;
          state_d = A_RD_REQ;
        end
      end
      A_RD_REQ: begin
        if (bmem.bmem_ready) begin
          bmem.bmem_read = 1'b1;
          bmem.bmem_addr = addr_q;
          state_d        = A_RD_WAIT;
        end
      end
      A_RD_WAIT: begin
        if (bmem.bmem_rvalid && (bmem.bmem_raddr == addr_q)) begin
          line_d[beat_lsb(cnt_q) +: BEAT_W] = bmem.bmem_rdata;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) state_d = A_DONE;
        end
      end
      A_WR_BURST: begin
        bmem.bmem_addr  = addr_q;
        bmem.bmem_wdata = line_q[beat_lsb(cnt_q) +: BEAT_W];
        bmem.bmem_write = bmem.bmem_ready;
        if (bmem.bmem_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) state_d = A_DONE;
        end
      end
      A_DONE: begin
        dfp.dfp_resp  = 1'b1;
        dfp.dfp_rdata = line_q;
        state_d       = A_IDLE;
      end
      default: state_d = A_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= A_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      line_q <= '0;
    end else begin
      addr_q <= addr_d;
      line_q <= line_d;
    end
  end

  // A returning beat for some other line while a read is outstanding is dropped.
  stray_beat_a : assert property (@(posedge clk) disable iff (rst)
    (state_q == A_RD_WAIT && bmem.bmem_rvalid) |-> (bmem.bmem_raddr == addr_q))
    else $warning("cacheline_adapter: dropped beat for raddr %h", bmem.bmem_raddr);

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed self-checking bench for cacheline_adapter.
module tb_cacheline_adapter;
  import rv32i_types::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_dfp_if  dfp ();
  cacheline_bmem_if bmem ();

  cacheline_adapter dut (
    .clk  (clk),
    .rst  (rst),
    .dfp  (dfp.slave),
    .bmem (bmem.master)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Passive monitor: cumulative event counts and the write-beat log.
  int unsigned rd_cmds = 0;
  int unsigned wr_beats = 0;
  int unsigned resps = 0;
  logic [BEAT_W-1:0] wlog [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bmem.bmem_read)  rd_cmds++;
      if (bmem.bmem_write) begin
        wr_beats++;
        wlog.push_back(bmem.bmem_wdata);
      end
      if (dfp.dfp_resp) resps++;
    end
  end

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic give_beat(input logic [31:0] raddr, input logic [BEAT_W-1:0] data);
    bmem.bmem_rvalid = 1'b1;
    bmem.bmem_raddr  = raddr;
    bmem.bmem_rdata  = data;
    step();
    bmem.bmem_rvalid = 1'b0;
  endtask

  localparam logic [BEAT_W-1:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [BEAT_W-1:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [BEAT_W-1:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [BEAT_W-1:0] B4 = 64'h4444_4444_4444_4444;
  localparam logic [BEAT_W-1:0] WA = 64'hA0A0_A0A0_0000_000A;
  localparam logic [BEAT_W-1:0] WB = 64'hB0B0_B0B0_0000_000B;
  localparam logic [BEAT_W-1:0] WC = 64'hC0C0_C0C0_0000_000C;
  localparam logic [BEAT_W-1:0] WD = 64'hD0D0_D0D0_0000_000D;

  initial begin
    int unsigned rd0, wr0, rs0, base;
    logic [BEAT_W-1:0] exp_w [4];
    logic [BEAT_W-1:0] g [4];

    rst = 1'b1;
    dfp.dfp_addr = '0; dfp.dfp_read = 1'b0; dfp.dfp_write = 1'b0; dfp.dfp_wdata = '0;
    bmem.bmem_ready = 1'b1; bmem.bmem_raddr = '0; bmem.bmem_rdata = '0; bmem.bmem_rvalid = 1'b0;
    step(); step();
    sample();
    check("rst_resp",  dfp.dfp_resp, 0);
    check("rst_rdata", dfp.dfp_rdata, 0);
    check("rst_read",  bmem.bmem_read, 0);
    check("rst_write", bmem.bmem_write, 0);
    check("rst_addr",  bmem.bmem_addr, 0);
    rst = 1'b0;
    step();

    // Read, ready=1
    rd0 = rd_cmds; rs0 = resps;
    dfp.dfp_addr = 32'h1234_5678; dfp.dfp_read = 1'b1;
    step();
    sample();
    check("rd1_cmd",  bmem.bmem_read, 1);
    check("rd1_addr", bmem.bmem_addr, 32'h1234_5660);
    step();
    sample();
    check("rd1_cmd_once", bmem.bmem_read, 0);
    give_beat(32'h1234_5660, B1);
    give_beat(32'h1234_5660, B2);
    give_beat(32'h1234_5660, B3);
    give_beat(32'h1234_5660, B4);
    sample();
    check("rd1_resp",  dfp.dfp_resp, 1);
    check("rd1_rdata", dfp.dfp_rdata, {B4, B3, B2, B1});
    step();
    dfp.dfp_read = 1'b0;
    sample();
    check("rd1_resp_pulse", dfp.dfp_resp, 0);
    step();
    check("rd1_ncmd",  rd_cmds - rd0, 1);
    check("rd1_nresp", resps - rs0, 1);

    // Write with a two-cycle stall after the first beat
    wr0 = wr_beats; rs0 = resps; base = wlog.size();
    dfp.dfp_addr = 32'h0000_101F; dfp.dfp_wdata = {WD, WC, WB, WA}; dfp.dfp_write = 1'b1;
    step();
    sample();
    check("wr_b0_strobe", bmem.bmem_write, 1);
    check("wr_b0_data",   bmem.bmem_wdata, WA);
    check("wr_addr",      bmem.bmem_addr, 32'h0000_1000);
    step();
    bmem.bmem_ready = 1'b0;
    sample();
    check("wr_stall_strobe", bmem.bmem_write, 0);
    check("wr_stall_data",   bmem.bmem_wdata, WB);
    step();
    sample();
    check("wr_stall2_data",  bmem.bmem_wdata, WB);
    step();
    bmem.bmem_ready = 1'b1;
    sample();
    check("wr_b1_data", bmem.bmem_wdata, WB);
    step(); step(); step();
    sample();
    check("wr_resp",  dfp.dfp_resp, 1);
    check("wr_rdata", dfp.dfp_rdata, {WD, WC, WB, WA});
    step();
    dfp.dfp_write = 1'b0;
    step();
    check("wr_nbeats", wr_beats - wr0, 4);
    check("wr_nresp",  resps - rs0, 1);
    exp_w = '{WA, WB, WC, WD};
    for (int i = 0; i < 4; i++)
      check($sformatf("wr_order%0d", i), wlog[base + i], exp_w[i]);

    // Gapped read beats with a stray beat for another line
    rs0 = resps;
    g = '{64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
          64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404};
    dfp.dfp_addr = 32'h0000_0080; dfp.dfp_read = 1'b1;
    step(); step();
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 1) give_beat(32'h0000_0040, 64'hBAD0_BAD0_BAD0_BAD0);
      else step();
      step();
      give_beat(32'h0000_0080, g[k]);
      if (k < 3) begin
        sample();
        check($sformatf("gap_noresp%0d", k), dfp.dfp_resp, 0);
      end
    end
    sample();
    check("gap_resp",  dfp.dfp_resp, 1);
    check("gap_rdata", dfp.dfp_rdata, {g[3], g[2], g[1], g[0]});
    step();
    dfp.dfp_read = 1'b0;
    step(); step();
    check("gap_nresp", resps - rs0, 1);

    // Read and write together: write only
    rd0 = rd_cmds; wr0 = wr_beats;
    dfp.dfp_addr = 32'h0000_0200; dfp.dfp_wdata = {B1, B2, B3, B4};
    dfp.dfp_read = 1'b1; dfp.dfp_write = 1'b1;
    step();
    sample();
    check("both_write", bmem.bmem_write, 1);
    check("both_noread", bmem.bmem_read, 0);
    step(); step(); step(); step();
    sample();
    check("both_resp", dfp.dfp_resp, 1);
    step();
    dfp.dfp_read = 1'b0; dfp.dfp_write = 1'b0;
    step(); step();
    check("both_nread",  rd_cmds - rd0, 0);
    check("both_nbeats", wr_beats - wr0, 4);

    // Reset mid-read, then a fresh read of the same line
    rs0 = resps;
    dfp.dfp_addr = 32'h0000_0300; dfp.dfp_read = 1'b1;
    step(); step();
    give_beat(32'h0000_0300, 64'hDEAD_0000_0000_0001);
    give_beat(32'h0000_0300, 64'hDEAD_0000_0000_0002);
    rst = 1'b1; dfp.dfp_read = 1'b0;
    step();
    rst = 1'b0;
    step();
    give_beat(32'h0000_0300, 64'hDEAD_0000_0000_0003);
    give_beat(32'h0000_0300, 64'hDEAD_0000_0000_0004);
    step();
    check("rst_mid_noresp", resps - rs0, 0);
    dfp.dfp_read = 1'b1;
    step();
    sample();
    check("rst_next_cmd", bmem.bmem_read, 1);
    step();
    give_beat(32'h0000_0300, 64'h5555_0000_0000_0001);
    give_beat(32'h0000_0300, 64'h5555_0000_0000_0002);
    give_beat(32'h0000_0300, 64'h5555_0000_0000_0003);
    give_beat(32'h0000_0300, 64'h5555_0000_0000_0004);
    sample();
    check("rst_next_resp", dfp.dfp_resp, 1);
    check("rst_next_rdata", dfp.dfp_rdata,
          {64'h5555_0000_0000_0004, 64'h5555_0000_0000_0003,
           64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001});
    step();
    dfp.dfp_read = 1'b0;
    step();

    // Back-to-back reads: request dropped one cycle after resp
    rd0 = rd_cmds; rs0 = resps;
    dfp.dfp_addr = 32'h0000_0400; dfp.dfp_read = 1'b1;
    step(); step();
    for (int k = 0; k < 4; k++) give_beat(32'h0000_0400, g[k]);
    sample();
    check("b2b_resp1", dfp.dfp_resp, 1);
    check("b2b_done_noread", bmem.bmem_read, 0);
    step();
    dfp.dfp_read = 1'b0;
    sample();
    check("b2b_idle_noread", bmem.bmem_read, 0);
    step();
    dfp.dfp_addr = 32'h0000_0440; dfp.dfp_read = 1'b1;
    step();
    sample();
    check("b2b_cmd2_addr", bmem.bmem_addr, 32'h0000_0440);
    step();
    for (int k = 0; k < 4; k++) give_beat(32'h0000_0440, exp_w[k]);
    sample();
    check("b2b_resp2",  dfp.dfp_resp, 1);
    check("b2b_rdata2", dfp.dfp_rdata, {WD, WC, WB, WA});
    step();
    dfp.dfp_read = 1'b0;
    step(); step();
    check("b2b_ncmd",  rd_cmds - rd0, 2);
    check("b2b_nresp", resps - rs0, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
